// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline register with an optional
// two-entry skid buffer, flush and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int unsigned DATA_W         = 128,
    parameter bit          SKID_EN        = 1'b1,
    parameter bit          CLEAR_ON_FLUSH = 1'b1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_cnt_clr
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              rdy_q, rdy_d;
    logic [1:0]        occ_q, occ_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_xfer;
    logic              out_xfer;

    // With the skid buffer in_ready comes straight from a flop, so there
    // is no combinational path from out_ready back to the producer.
    assign in_ready  = SKID_EN ? rdy_q : (!main_v_q || out_ready);
    assign out_valid = main_v_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;
    assign stall_cnt = cnt_q;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = main_v_q && out_ready;

    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d   = main_q;
        skid_d   = skid_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            if (CLEAR_ON_FLUSH) begin
                main_d = '0;
                skid_d = '0;
            end
        end else if (SKID_EN) begin
            if (skid_v_q) begin
                if (out_xfer) begin
                    main_d   = skid_q;
                    skid_v_d = 1'b0;
                end
            end else if (main_v_q) begin
                if (in_xfer && out_xfer) begin
                    main_d = in_data;
                end else if (in_xfer) begin
                    skid_d   = in_data;
                    skid_v_d = 1'b1;
                end else if (out_xfer) begin
                    main_v_d = 1'b0;
                end
            end else if (in_xfer) begin
                main_d   = in_data;
                main_v_d = 1'b1;
            end
        end else begin
            if (in_xfer) begin
                main_d   = in_data;
                main_v_d = 1'b1;
            end else if (out_xfer) begin
                main_v_d = 1'b0;
            end
        end
    end

    always_comb begin
        rdy_d = !skid_v_d;
        occ_d = {1'b0, main_v_d} + {1'b0, skid_v_d};
        cnt_d = cnt_q;
        if (stall_cnt_clr) begin
            cnt_d = '0;
        end else if (main_v_q && !out_ready && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
            rdy_q    <= 1'b1;
            occ_q    <= 2'd0;
            cnt_q    <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            rdy_q    <= rdy_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: FIFO-queue model checked every cycle for a
// skid instance (index 0) and a single-register instance (index 1).
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic [1:0]  rst = 2'b00;
    logic [1:0]  flush = 2'b00;
    logic [1:0]  iv = 2'b00;
    logic [1:0]  ordy = 2'b00;
    logic [1:0]  clr = 2'b00;
    logic [31:0] idat [2];
    logic [1:0]  ir;
    logic [1:0]  ov;
    logic [31:0] od [2];
    logic [1:0]  occ [2];
    logic [3:0]  sc [2];

    int nchk = 0;
    int nerr = 0;

    // model: a FIFO of live payloads per instance
    int          n [2];
    logic [31:0] mem [2][2];
    bit          zk [2];
    int          cnt [2];
    bit          started [2];

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W(32), .SKID_EN(1'b1), .CLEAR_ON_FLUSH(1'b1), .CNT_W(4)
    ) dut_skid (
        .clk(clk), .rst(rst[0]), .flush(flush[0]),
        .in_valid(iv[0]), .in_data(idat[0]), .in_ready(ir[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy[0]),
        .occupancy(occ[0]), .stall_cnt(sc[0]), .stall_cnt_clr(clr[0])
    );

    pipe_stage_reg #(
        .DATA_W(32), .SKID_EN(1'b0), .CLEAR_ON_FLUSH(1'b1), .CNT_W(4)
    ) dut_flat (
        .clk(clk), .rst(rst[1]), .flush(flush[1]),
        .in_valid(iv[1]), .in_data(idat[1]), .in_ready(ir[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy[1]),
        .occupancy(occ[1]), .stall_cnt(sc[1]), .stall_cnt_clr(clr[1])
    );

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    function automatic bit exp_ir(input int k);
        if (k == 0) return n[k] < 2;
        return (n[k] == 0) || (ordy[k] == 1'b1);
    endfunction

    task automatic mstep(input int k);
        bit ix;
        bit ox;
        if (rst[k]) begin
            n[k] = 0;
            cnt[k] = 0;
            zk[k] = 1'b1;
            started[k] = 1'b1;
        end else if (started[k]) begin
            ix = iv[k] && exp_ir(k);
            ox = (n[k] > 0) && ordy[k];
            if (clr[k]) cnt[k] = 0;
            else if (n[k] > 0 && !ordy[k] && cnt[k] < 15) cnt[k]++;
            if (flush[k]) begin
                n[k] = 0;
                zk[k] = 1'b1;
            end else begin
                if (ox) begin
                    mem[k][0] = mem[k][1];
                    n[k]--;
                end
                if (ix) begin
                    mem[k][n[k]] = idat[k];
                    n[k]++;
                    zk[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic mcheck(input int k);
        chk($sformatf("m%0d_valid", k), 32'(ov[k]), 32'(n[k] > 0));
        chk($sformatf("m%0d_occ", k), 32'(occ[k]), 32'(n[k]));
        chk($sformatf("m%0d_stall", k), 32'(sc[k]), 32'(cnt[k]));
        chk($sformatf("m%0d_ready", k), 32'(ir[k]), 32'(exp_ir(k)));
        if (n[k] > 0)
            chk($sformatf("m%0d_data", k), od[k], mem[k][0]);
        else if (zk[k])
            chk($sformatf("m%0d_zero", k), od[k], 32'h0);
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) mstep(k);
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++)
            if (started[k]) mcheck(k);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            n[k] = 0;
            cnt[k] = 0;
            zk[k] = 1'b1;
            started[k] = 1'b0;
            idat[k] = 32'h0;
        end
        // T1 reset and streaming
        rst = 2'b11;
        tick();
        tick();
        rst = 2'b00;
        chk("t1_rst_valid", 32'(ov[0]), 32'h0);
        chk("t1_rst_occ", 32'(occ[0]), 32'h0);
        chk("t1_rst_data", od[0], 32'h0);
        chk("t1_rst_ready", 32'(ir[0]), 32'h1);
        ordy[0] = 1'b1;
        iv[0] = 1'b1;
        idat[0] = 32'h10;
        tick();
        chk("t1_d10", od[0], 32'h10);
        idat[0] = 32'h11;
        tick();
        chk("t1_d11", od[0], 32'h11);
        idat[0] = 32'h12;
        tick();
        chk("t1_d12", od[0], 32'h12);
        chk("t1_ready", 32'(ir[0]), 32'h1);
        iv[0] = 1'b0;
        tick();
        chk("t1_stall", 32'(sc[0]), 32'h0);
        // T2 skid fill
        iv[0] = 1'b1;
        idat[0] = 32'hA1;
        ordy[0] = 1'b0;
        tick();
        idat[0] = 32'hA2;
        tick();
        iv[0] = 1'b0;
        chk("t2_occ2", 32'(occ[0]), 32'h2);
        chk("t2_rdy0", 32'(ir[0]), 32'h0);
        chk("t2_hold", od[0], 32'hA1);
        ordy[0] = 1'b1;
        tick();
        chk("t2_second", od[0], 32'hA2);
        chk("t2_rdy1", 32'(ir[0]), 32'h1);
        tick();
        chk("t2_empty", 32'(ov[0]), 32'h0);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        // T3 flush with simultaneous input
        iv[0] = 1'b1;
        ordy[0] = 1'b0;
        idat[0] = 32'hB1;
        tick();
        idat[0] = 32'hB2;
        tick();
        flush[0] = 1'b1;
        idat[0] = 32'hB3;
        tick();
        flush[0] = 1'b0;
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        chk("t3_valid", 32'(ov[0]), 32'h0);
        chk("t3_occ", 32'(occ[0]), 32'h0);
        chk("t3_data", od[0], 32'h0);
        chk("t3_ready", 32'(ir[0]), 32'h1);
        // flush while ready: accepted input is dropped
        iv[0] = 1'b1;
        idat[0] = 32'hB4;
        flush[0] = 1'b1;
        tick();
        flush[0] = 1'b0;
        iv[0] = 1'b0;
        tick();
        chk("t3_drop", 32'(ov[0]), 32'h0);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        // T4 stall counter saturation
        iv[0] = 1'b1;
        idat[0] = 32'hE1;
        ordy[0] = 1'b0;
        tick();
        iv[0] = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("t4_sat", 32'(sc[0]), 32'd15);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        chk("t4_clr", 32'(sc[0]), 32'd0);
        tick();
        chk("t4_one", 32'(sc[0]), 32'd1);
        ordy[0] = 1'b1;
        tick();
        // T5 single register, combinational ready
        iv[1] = 1'b1;
        idat[1] = 32'hC1;
        tick();
        chk("t5_c1", od[1], 32'hC1);
        idat[1] = 32'hC2;
        #1;
        chk("t5_rdy0", 32'(ir[1]), 32'h0);
        ordy[1] = 1'b1;
        #1;
        chk("t5_rdy1", 32'(ir[1]), 32'h1);
        tick();
        chk("t5_c2", od[1], 32'hC2);
        chk("t5_c2v", 32'(ov[1]), 32'h1);
        idat[1] = 32'hC3;
        tick();
        chk("t5_c3", od[1], 32'hC3);
        iv[1] = 1'b0;
        tick();
        chk("t5_empty", 32'(ov[1]), 32'h0);
        // T6 reset while full
        iv[0] = 1'b1;
        ordy[0] = 1'b0;
        idat[0] = 32'hD1;
        tick();
        idat[0] = 32'hD2;
        tick();
        iv[0] = 1'b0;
        rst[0] = 1'b1;
        ordy[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk("t6_valid", 32'(ov[0]), 32'h0);
        chk("t6_occ", 32'(occ[0]), 32'h0);
        chk("t6_data", od[0], 32'h0);
        chk("t6_stall", 32'(sc[0]), 32'h0);
        chk("t6_ready", 32'(ir[0]), 32'h1);
        tick();
        chk("t6_after", 32'(ov[0]), 32'h0);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register that replaces hard-coded per-stage registers (ID/EX, EX/MEM, ...) with a single generic block.
- Carries an opaque DATA_W-bit payload under a valid/ready handshake. An optional 2-entry skid buffer keeps in_ready registered.
- Supports flush (kill contents) and a saturating stall-cycle counter for performance monitoring.
- Sits between any two pipeline stages. The producer stage drives in_*; the consumer stage drives out_ready.

Parameters:
- DATA_W, 128: payload width in bits (stage packs op type, PC, operands, immediate, register addresses, jump target).
- SKID_EN, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CLEAR_ON_FLUSH, 1: 1 = payload registers zeroed on flush; 0 = only valid bits cleared, payload retained.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk, in, 1: clock, all state updates on rising edge.
- rst, in, 1: reset.
- flush, in, 1: kill all held entries this cycle.
- in_valid, in, 1: producer has payload.
- in_data, in, DATA_W: producer payload.
- in_ready, out, 1: stage can accept in_data this cycle.
- out_valid, out, 1: out_data holds a live entry.
- out_data, out, DATA_W: payload to consumer.
- out_ready, in, 1: consumer accepts out_data this cycle.
- occupancy, out, 2: live entries held (0..2; max 1 when SKID_EN=0).
- stall_cnt, out, CNT_W: saturating count of cycles with out_valid=1 and out_ready=0.
- stall_cnt_clr, in, 1: clear stall_cnt.

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: sampled on a rising clk edge with rst=1. Sets out_valid=0, skid valid=0, out_data=0, skid data=0, occupancy=0, stall_cnt=0. in_ready=1 from the first cycle after reset (SKID_EN=1). Reset mid-transfer drops all entries without exception; rst has priority over every other input.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - No payload is duplicated or lost except on flush or rst.
  - Latency in→out is 1 cycle when the stage is empty.
- SKID_EN=1:
  - State is {main, skid}, giving three states: EMPTY (main invalid), ONE (main valid, skid invalid), FULL (both valid).
  - in_ready is a register equal to !skid_valid.
  - EMPTY + input transfer → ONE, main <= in_data.
  - ONE + input + output transfers → ONE, main <= in_data.
  - ONE + input transfer, no output transfer → FULL, skid <= in_data; main is held unchanged.
  - ONE + output transfer only → EMPTY.
  - FULL + output transfer → ONE, main <= skid. No input transfer is possible in FULL because in_ready=0.
  - FULL with no output transfer holds all state.
  - Ordering is strictly FIFO.
- SKID_EN=0:
  - Single register; in_ready = !out_valid | out_ready (combinational).
  - Load on input transfer. Clear out_valid on an output transfer with no input transfer.
  - occupancy[1] is tied to 0.
- Flush:
  - Synchronous. In the flush cycle, main and skid valid bits are cleared.
  - Any input transfer in the same cycle is discarded, so the producer sees in_ready as asserted but the data is dropped.
  - With CLEAR_ON_FLUSH=1 the payload registers are zeroed; otherwise they are retained.
  - Next cycle: out_valid=0, occupancy=0, in_ready=1.
  - Priority: rst > flush > transfers.
- out_data is always driven from the main register. While out_valid=0 its value is don't-care, except that it must be 0 after rst or after a flush with CLEAR_ON_FLUSH=1.
- occupancy = main_valid + skid_valid, registered.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1; no wrap-around.
  - stall_cnt_clr sets it to 0 and takes priority over increment in the same cycle.
  - Flush does not clear it.
- No combinational path from out_ready to in_ready when SKID_EN=1.

Test Plan:
- T1 Reset and streaming (SKID_EN=1, DATA_W=32): assert rst 2 cycles, then in_valid=1 with data 0x10,0x11,0x12 on consecutive cycles, out_ready=1. Required: out_data shows 0x10,0x11,0x12 one cycle later, out_valid continuous, in_ready stays 1, stall_cnt=0.
- T2 Skid fill: load 0xA1, drop out_ready, then present 0xA2. Required: occupancy=2 and in_ready=0 in the following cycle; out_data holds 0xA1. Raise out_ready: outputs 0xA1 then 0xA2 in order, in_ready=1 one cycle after the first output transfer.
- T3 Flush with simultaneous input: stage FULL (0xB1,0xB2), assert flush with in_valid=1, in_data=0xB3. Required next cycle: out_valid=0, occupancy=0, out_data=0 (CLEAR_ON_FLUSH=1); 0xB3 never appears.
- T4 Stall counter (CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles. Required: stall_cnt=15 and held there. Pulse stall_cnt_clr with the stall still present: value 0 after that edge, 1 the following cycle.
- T5 SKID_EN=0: out_valid=1, out_ready=0, in_valid=1 with in_data=0xC2. Required: in_ready=0 the same cycle. Raise out_ready: in_ready=1 combinationally, 0xC2 loads with zero-bubble back-to-back transfer.
- T6 Reset mid-operation: FULL state, assert rst together with flush=0 and out_ready=1. Required: no output transfer is counted; all outputs are at their reset values next cycle.
